sifh_hist_engine: RTL
=====================

// Module: sifh_hist_engine
// PURPOSE
//  Parametrised SPAD timestamp histogrammer for the dToF pixel array. Clears a shared histogram RAM,
//  accumulates ACQ_NUM timestamp events per acquisition by pipelined read-modify-write, then scans
//  every pixel's histogram and reports its peak bin. Sits between the TDC/event mux and the
//  dual-port histogram RAM; the peak stream feeds the depth-output block.
// PARAMETERS
//  NP       16      event word width; address field is data[AW-1:0], AW = PIX_BITS+NB
//  NB       6       bin address bits (2^NB bins per pixel histogram)
//  PIX_BITS 2       pixel address bits (2^PIX_BITS pixels per RAM)
//  CNT_W    10      bin counter width
//  ACQ_NUM  4096    events accepted per acquisition (1..2^24-1)
// PORTS
//  clk         in   1       clock
//  res         in   1       async reset, active low
//  start       in   1       1-cycle pulse: begin clear+acquire+scan; ignored unless busy==0
//  data_valid  in   1       event present on data
//  data        in   NP      event word {.., pixel, bin}
//  data_ready  out  1       event accepted when data_valid & data_ready
//  raddr       out  AW      RAM port B address
//  rEnable     out  1       RAM port B read enable (1 = read)
//  readFlag    out  1       RAM port B memory enable
//  counts      in   CNT_W   RAM port B read data, valid 1 cycle after rEnable
//  waddr       out  AW      RAM port A address
//  wEnable     out  1       RAM port A write enable (1 = write)
//  writeFlag   out  1       RAM port A memory enable
//  newCounts   out  CNT_W   RAM port A write data
//  peak_valid  out  1       1-cycle pulse, peak_* valid
//  peak_pixel  out  PIX_BITS  pixel index of reported peak
//  peak_bin    out  NB      bin of maximum count (lowest bin on ties)
//  peak_count  out  CNT_W   maximum count
//  sat_flag    out  1       sticky: some bin saturated this acquisition; cleared by start
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse after last peak_valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, event counter 0. Reset mid-operation aborts; RAM contents undefined.
//  States: IDLE -start-> CLEAR -last addr written-> ACQ -ACQ_NUM accepted-> DRAIN -pipe empty-> SCAN
//   -last pixel reported-> IDLE (done pulse). All outputs registered.
//  CLEAR: waddr 0..2^AW-1, one per cycle, wEnable=writeFlag=1, newCounts=0; 2^AW cycles; data_ready=0.
//  ACQ: data_ready=1 while accepted < ACQ_NUM; drops to 0 in the cycle after the ACQ_NUM-th accept.
//   Event accepted cycle t -> raddr=A, rEnable=readFlag=1 at t+1 -> counts at t+2 ->
//   waddr=A, newCounts=src+1, wEnable=writeFlag=1 at t+3. Throughput 1 event/cycle.
//  Hazard: src = value of youngest in-flight update to A (forwarded from write stage or stage t+2),
//   else counts. Any burst of identical addresses must count exactly.
//  Saturation: src == 2^CNT_W-1 -> newCounts stays 2^CNT_W-1, sat_flag<=1.
//  DRAIN: no accepts; waits until the 3-stage pipe is empty (max 3 cycles).
//  SCAN: raddr sweeps 0..2^AW-1 one per cycle; per pixel track max with strict '>' (first wins);
//   peak_valid pulses 2 cycles after last bin of each pixel read; pixels reported in ascending order.
//  start while busy: ignored. data_valid outside ACQ: not accepted, no effect.
//  Event counter 24 bit, compares to ACQ_NUM; no wrap within an acquisition.
// STRUCTURE
//  parametersSiFH.vh: NP, NB, PIX_BITS, CNT_W, ACQ_NUM defaults, AW derivation, state encodings.
//  Sub-module sifh_rmw_pipe: 3-stage read-modify-write with forwarding + saturation; FSM owns sequencing,
//   clear/scan address generators, peak tracker.
// TESTING
//  Bench uses behavioural 1-cycle-read dual-port RAM model, NB=3, PIX_BITS=1, CNT_W=4 unless stated.
//  1 Reset during ACQ -> all outputs 0 next cycle; new start -> full CLEAR of 16 addrs, all bins read 0.
//  2 ACQ_NUM=8, 8 back-to-back events to addr 5 -> RAM[5]=8, others 0, peak pixel0 bin5 count8.
//  3 Alternating addrs 3,3,4,3,4,4 consecutive -> RAM[3]=3, RAM[4]=3; pixel0 peak bin3 (tie, lowest).
//  4 ACQ_NUM=20, 20 events to addr 9 -> RAM[9]=15, sat_flag=1; next start clears sat_flag.
//  5 Pixel1 bins 2,6 get 1,4 hits -> peak_valid twice: (0,bin0,0) then (1,bin6,4); done one cycle later.
//  6 start pulsed during SCAN and data_valid held high in IDLE -> no effect, data_ready stays 0.

Source files
------------

// File: rtl/sifh_hist_engine_pkg.sv
// rtl/sifh_hist_engine_pkg.sv - shared defaults, widths and FSM encoding for the SPAD histogram engine
package sifh_hist_engine_pkg;

  localparam int NP_DEF       = 16;
  localparam int NB_DEF       = 6;
  localparam int PIX_BITS_DEF = 2;
  localparam int CNT_W_DEF    = 10;
  localparam int ACQ_NUM_DEF  = 4096;
  localparam int EVCNT_W      = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4
  } state_t;

endpackage

// File: rtl/sifh_hist_engine_if.sv
// rtl/sifh_hist_engine_if.sv - event input, dual-port RAM and peak-output bundle of the histogram engine
interface sifh_hist_engine_if
  import sifh_hist_engine_pkg::*;
#(
  parameter int NP       = NP_DEF,
  parameter int NB       = NB_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) ();
  localparam int AW = PIX_BITS + NB;

  logic                start;
  logic                data_valid;
  logic [NP-1:0]       data;
  logic                data_ready;
  logic [AW-1:0]       raddr;
  logic                rEnable;
  logic                readFlag;
  logic [CNT_W-1:0]    counts;
  logic [AW-1:0]       waddr;
  logic                wEnable;
  logic                writeFlag;
  logic [CNT_W-1:0]    newCounts;
  logic                peak_valid;
  logic [PIX_BITS-1:0] peak_pixel;
  logic [NB-1:0]       peak_bin;
  logic [CNT_W-1:0]    peak_count;
  logic                sat_flag;
  logic                busy;
  logic                done;

  modport slave (
    input  start, data_valid, data, counts,
    output data_ready, raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts,
           peak_valid, peak_pixel, peak_bin, peak_count, sat_flag, busy, done
  );

  modport master (
    output start, data_valid, data, counts,
    input  data_ready, raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts,
           peak_valid, peak_pixel, peak_bin, peak_count, sat_flag, busy, done
  );

endinterface

// File: rtl/sifh_hist_engine_rmw_pipe.sv
// rtl/sifh_hist_engine_rmw_pipe.sv - 3-stage read-modify-write bin incrementer with forwarding and saturation
module sifh_hist_engine_rmw_pipe #(
  parameter int AW    = 8,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             res,
  input  logic             rd_req_i,
  input  logic             rd_upd_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             clr_req_i,
  input  logic [AW-1:0]    clr_addr_i,
  input  logic             sat_clr_i,
  input  logic [CNT_W-1:0] counts_i,
  output logic [AW-1:0]    raddr_o,
  output logic             ren_o,
  output logic [AW-1:0]    waddr_o,
  output logic             wen_o,
  output logic [CNT_W-1:0] wdata_o,
  output logic             sat_o,
  output logic             busy_o
);

  logic [AW-1:0]    raddr_q;
  logic             ren_q;
  logic             s1_v_q;
  logic             s2_v_q;
  logic [AW-1:0]    s2_addr_q;
  logic [AW-1:0]    waddr_q;
  logic             wen_q;
  logic             w_upd_q;
  logic [CNT_W-1:0] wdata_q;
  logic             wp_v_q;
  logic [AW-1:0]    wp_addr_q;
  logic [CNT_W-1:0] wp_data_q;
  logic             sat_q;

  logic [CNT_W-1:0] src_d;
  logic [CNT_W-1:0] upd_d;
  logic             at_max_d;

  // The write retired one cycle ago raced the RAM read of this update, so it
  // is forwarded as well; the write in flight now is younger and wins.
  always_comb begin
    src_d = counts_i;
    if (wp_v_q && (wp_addr_q == s2_addr_q)) src_d = wp_data_q;
    if (w_upd_q && (waddr_q == s2_addr_q)) src_d = wdata_q;
    at_max_d = &src_d;
    upd_d    = at_max_d ? src_d : src_d + 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      raddr_q   <= '0;
      ren_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      w_upd_q   <= 1'b0;
      wdata_q   <= '0;
      wp_v_q    <= 1'b0;
      wp_addr_q <= '0;
      wp_data_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      ren_q     <= rd_req_i;
      if (rd_req_i) raddr_q <= rd_addr_i;
      s1_v_q    <= rd_req_i & rd_upd_i;
      s2_v_q    <= s1_v_q;
      s2_addr_q <= raddr_q;
      wp_v_q    <= w_upd_q;
      wp_addr_q <= waddr_q;
      wp_data_q <= wdata_q;
      if (s2_v_q) begin
        waddr_q <= s2_addr_q;
        wdata_q <= upd_d;
        wen_q   <= 1'b1;
        w_upd_q <= 1'b1;
      end else if (clr_req_i) begin
        waddr_q <= clr_addr_i;
        wdata_q <= '0;
        wen_q   <= 1'b1;
        w_upd_q <= 1'b0;
      end else begin
        wen_q   <= 1'b0;
        w_upd_q <= 1'b0;
      end
      if (sat_clr_i) sat_q <= 1'b0;
      else if (s2_v_q && at_max_d) sat_q <= 1'b1;
    end
  end

  assign raddr_o = raddr_q;
  assign ren_o   = ren_q;
  assign waddr_o = waddr_q;
  assign wen_o   = wen_q;
  assign wdata_o = wdata_q;
  assign sat_o   = sat_q;
  assign busy_o  = s1_v_q | s2_v_q | w_upd_q;

endmodule

// File: rtl/sifh_hist_engine.sv
// rtl/sifh_hist_engine.sv - clear/acquire/scan sequencer and per-pixel peak finder over a shared histogram RAM
module sifh_hist_engine
  import sifh_hist_engine_pkg::*;
#(
  parameter int NP       = NP_DEF,
  parameter int NB       = NB_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ACQ_NUM  = ACQ_NUM_DEF
) (
  input logic                clk,
  input logic                res,
  sifh_hist_engine_if.slave  hif
);

  localparam int AW = PIX_BITS + NB;
  localparam logic [AW-1:0]      ADDR_LAST = '1;
  localparam logic [EVCNT_W-1:0] ACQ_LAST  = EVCNT_W'(ACQ_NUM - 1);

  state_t              state_q;
  logic [AW-1:0]       addr_q;
  logic [EVCNT_W-1:0]  evcnt_q;
  logic                data_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                scan_rd_q;
  logic                sc1_v_q;
  logic [AW-1:0]       sc1_addr_q;
  logic                sc2_v_q;
  logic [AW-1:0]       sc2_addr_q;
  logic [CNT_W-1:0]    max_cnt_q;
  logic [NB-1:0]       max_bin_q;
  logic                peak_valid_q;
  logic [PIX_BITS-1:0] peak_pixel_q;
  logic [NB-1:0]       peak_bin_q;
  logic [CNT_W-1:0]    peak_count_q;

  logic                start_ok;
  logic                accept;
  logic                rd_req;
  logic [AW-1:0]       rd_addr;
  logic                pipe_busy;
  logic [NB-1:0]       sc_bin;
  logic [PIX_BITS-1:0] sc_pix;
  logic                take;
  logic [CNT_W-1:0]    best_cnt;
  logic [NB-1:0]       best_bin;

  assign start_ok = (state_q == ST_IDLE) && hif.start;
  assign accept   = data_ready_q && hif.data_valid;
  assign rd_req   = accept | scan_rd_q;
  assign rd_addr  = accept ? hif.data[AW-1:0] : addr_q;

  sifh_hist_engine_rmw_pipe #(.AW(AW), .CNT_W(CNT_W)) u_rmw (
    .clk        (clk),
    .res        (res),
    .rd_req_i   (rd_req),
    .rd_upd_i   (accept),
    .rd_addr_i  (rd_addr),
    .clr_req_i  (state_q == ST_CLEAR),
    .clr_addr_i (addr_q),
    .sat_clr_i  (start_ok),
    .counts_i   (hif.counts),
    .raddr_o    (hif.raddr),
    .ren_o      (hif.rEnable),
    .waddr_o    (hif.waddr),
    .wen_o      (hif.wEnable),
    .wdata_o    (hif.newCounts),
    .sat_o      (hif.sat_flag),
    .busy_o     (pipe_busy)
  );

  // Bin 0 always seeds the tracker so a pixel never inherits its neighbour's max.
  assign sc_bin   = sc2_addr_q[NB-1:0];
  assign sc_pix   = sc2_addr_q[AW-1:NB];
  assign take     = (sc_bin == '0) || (hif.counts > max_cnt_q);
  assign best_cnt = take ? hif.counts : max_cnt_q;
  assign best_bin = take ? sc_bin : max_bin_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      evcnt_q      <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      scan_rd_q    <= 1'b0;
      sc1_v_q      <= 1'b0;
      sc1_addr_q   <= '0;
      sc2_v_q      <= 1'b0;
      sc2_addr_q   <= '0;
      max_cnt_q    <= '0;
      max_bin_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_pixel_q <= '0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else begin
      done_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      sc1_v_q      <= scan_rd_q;
      sc1_addr_q   <= addr_q;
      sc2_v_q      <= sc1_v_q;
      sc2_addr_q   <= sc1_addr_q;
      if (sc2_v_q) begin
        max_cnt_q <= best_cnt;
        max_bin_q <= best_bin;
        if (&sc_bin) begin
          peak_valid_q <= 1'b1;
          peak_pixel_q <= sc_pix;
          peak_bin_q   <= best_bin;
          peak_count_q <= best_cnt;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (hif.start) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        ST_CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_q      <= ST_ACQ;
            data_ready_q <= 1'b1;
            evcnt_q      <= '0;
          end
        end
        ST_ACQ: begin
          if (accept) begin
            evcnt_q <= evcnt_q + 1'b1;
            if (evcnt_q == ACQ_LAST) begin
              data_ready_q <= 1'b0;
              state_q      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            state_q   <= ST_SCAN;
            addr_q    <= '0;
            scan_rd_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_rd_q) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == ADDR_LAST) scan_rd_q <= 1'b0;
          end
          if (peak_valid_q && (&peak_pixel_q)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hif.data_ready = data_ready_q;
  assign hif.readFlag   = hif.rEnable;
  assign hif.writeFlag  = hif.wEnable;
  assign hif.peak_valid = peak_valid_q;
  assign hif.peak_pixel = peak_pixel_q;
  assign hif.peak_bin   = peak_bin_q;
  assign hif.peak_count = peak_count_q;
  assign hif.busy       = busy_q;
  assign hif.done       = done_q;

endmodule
